iodelay_tap_sweep_ctrl: RTL and testbench
=========================================

Name: iodelay_tap_sweep_ctrl

Overview:
- Per-lane receive-delay calibration sequencer for the LRX path, in the app_clk domain.
- Steps the IODELAY tap value across its range. For each point it drops EN_VTC, loads the tap, raises EN_VTC, then samples the lane integrity checker's sticky error flag.
- Tracks the longest contiguous passing window and finally loads its centre tap.
- Sits between the LRX top-level calibration start and the per-lane delay/RIU load path plus integrity checker.

Parameters:
- TAP_W, 9, width of delay count value.
- TAP_MAX, 511, highest tap swept (inclusive).
- TAP_STEP, 8, tap increment per sweep point.
- SETTLE_CYC, 16, wait cycles after EN_VTC drop and after load.
- CHECK_CYC, 256, cycles EN_VTC held high before sampling error_sb_i (must be > 8).
- MIN_WINDOW, 16, minimum passing window width in taps (end - start).

Ports:
- clk  in  1  app_clk; the only clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  single-cycle pulse that begins a calibration; ignored while busy_o=1.
- error_sb_i  in  1  sticky integrity error from the lane checker; cleared by the checker on the EN_VTC falling edge.
- en_vtc_o  out  1  EN_VTC to the delay element and checker.
- dly_load_o  out  1  one-cycle load strobe for the delay.
- dly_cntvalue_o  out  TAP_W  tap value to load; held stable between loads.
- busy_o  out  1  calibration in progress.
- done_o  out  1  level; calibration finished; cleared by the next accepted start_i.
- fail_o  out  1  level; no passing window of at least MIN_WINDOW; valid when done_o=1.
- win_start_o  out  TAP_W  first tap of best window.
- win_end_o  out  TAP_W  last tap of best window.
- final_tap_o  out  TAP_W  tap loaded at completion.

Behaviour:
- Reset values: en_vtc_o=1; all other outputs 0. The FSM returns to IDLE immediately (asynchronous), including when reset arrives mid-sweep.
- FSM states:
  - IDLE: start_i → VTC_LOW; set tap=0, busy_o=1, clear done_o/fail_o and the window tracker.
  - VTC_LOW: en_vtc_o=0 for SETTLE_CYC cycles → LOAD.
  - LOAD: dly_cntvalue_o=tap, dly_load_o=1 for exactly 1 cycle → LOAD_WAIT.
  - LOAD_WAIT: SETTLE_CYC cycles → VTC_HIGH.
  - VTC_HIGH: en_vtc_o=1 for CHECK_CYC cycles; error_sb_i is sampled on the last cycle → EVAL.
  - EVAL (1 cycle): pass = !sample; update tracker → STEP.
  - STEP (1 cycle):
    - if final_phase → DONE.
    - else if tap + TAP_STEP > TAP_MAX → FINAL, with the addition computed at TAP_W+1 bits (no wrap).
    - else tap += TAP_STEP → VTC_LOW.
  - FINAL:
    - if best width < MIN_WINDOW or no pass seen → DONE with fail_o=1, final_tap_o=0, no further load; en_vtc_o stays 1 and dly_cntvalue_o keeps the last swept tap.
    - else tap = win_start + ((win_end - win_start) >> 1) (floor), final_phase=1 → VTC_LOW, running the normal load/check sequence once.
  - DONE: busy_o=0, done_o=1, final_tap_o valid → IDLE the same cycle.
  - A start_i in DONE/IDLE begins a new run.
- Tracker:
  - A run starts at the first passing point after a fail (or at tap 0) and extends while points pass.
  - On each pass, if current width (tap - run_start) > best width, best := (run_start, tap). Strict greater-than, so ties keep the earlier window.
  - A fail ends the run.
  - A single passing point has width 0.
- The final-phase check result is ignored for window bookkeeping; a fail on it does not set fail_o.
- Per-point latency: 2*SETTLE_CYC + CHECK_CYC + 3 cycles. With defaults, 64 sweep points plus 1 final point.
- en_vtc_o changes only on state transitions; dly_load_o never coincides with en_vtc_o=1.
- start_i while busy_o=1 has no effect.

Decomposition:
- Package lrx_cal_pkg: FSM state enum, TAP_W default, tracker record type (run_start, best_start, best_end, in_run).
- One sub-module, cal_window_tracker: inputs eval strobe, pass, tap, clear; outputs best_start, best_end, best_width, any_pass.
- The FSM and a single shared down-counter timer stay in the top module.

Test Plan:
- Checker model always error=0, start pulse → 64 loads at 0..504, win 0..504, final load 252, fail_o=0, done_o=1.
- Pass only for taps 96..200 → win_start_o=96, win_end_o=200, final_tap_o=148.
- Pass at 16..48 and 304..400 → second window chosen, win 304..400, final_tap_o=352; equal-width windows 16..48 and 304..336 → first chosen, final_tap_o=32.
- Always error=1 → fail_o=1, final_tap_o=0, en_vtc_o=1 at done, no final load strobe; single pass at 256 → fail_o=1 (width 0 < 16).
- Assert rst during LOAD_WAIT of tap 40 → en_vtc_o=1 and busy_o=0 without waiting for a clock edge; restart completes correctly. Extra start_i while busy → load count unchanged.
- Checker error raised only in the final-phase check → fail_o stays 0; error_sb_i is cleared on each EN_VTC fall, so no stale fails carry into the next point.

Source files
------------

// File: rtl/lrx_cal_pkg.sv
// Shared types for the LRX receive-delay calibration sequencer.
//   cal_state_e : sweep FSM states
//   trk_t       : window tracker record (current run start, best window, run flag)
//   TAP_W_DEF   : tap width the tracker record is sized for
package lrx_cal_pkg;

   localparam int unsigned TAP_W_DEF = 9;

   typedef enum logic [3:0] {
      StIdle,
      StVtcLow,
      StLoad,
      StLoadWait,
      StVtcHigh,
      StEval,
      StStep,
      StFinal,
      StDone
   } cal_state_e;

   typedef struct packed {
      logic [TAP_W_DEF-1:0] run_start;
      logic [TAP_W_DEF-1:0] best_start;
      logic [TAP_W_DEF-1:0] best_end;
      logic                 in_run;
   } trk_t;

endpackage

// File: rtl/cal_window_tracker.sv
// Longest-contiguous-passing-window tracker for the tap sweep.
//   clk, rst   : app_clk, async active-high reset
//   clear      : drop all history (start of a calibration)
//   eval       : one sweep point result is presented this cycle
//   pass, tap  : result and tap value of that point
//   best_start / best_end / best_width : best window so far (width = end - start)
//   any_pass   : at least one passing point has been recorded
module cal_window_tracker
   import lrx_cal_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 eval,
   input  logic                 pass,
   input  logic [TAP_W_DEF-1:0] tap,
   output logic [TAP_W_DEF-1:0] best_start,
   output logic [TAP_W_DEF-1:0] best_end,
   output logic [TAP_W_DEF-1:0] best_width,
   output logic                 any_pass
);

   trk_t trk_q, trk_d;
   logic any_q, any_d;
   logic [TAP_W_DEF-1:0] cur_start;
   logic [TAP_W_DEF-1:0] cur_width;

   // A pass outside a run opens a new run at this tap.
   assign cur_start = trk_q.in_run ? trk_q.run_start : tap;
   assign cur_width = tap - cur_start;

   assign best_start = trk_q.best_start;
   assign best_end   = trk_q.best_end;
   assign best_width = trk_q.best_end - trk_q.best_start;
   assign any_pass   = any_q;

   always_comb begin
      trk_d = trk_q;
      any_d = any_q;
      if (clear) begin
         trk_d = '0;
         any_d = 1'b0;
      end else if (eval) begin
         if (pass) begin
            trk_d.run_start = cur_start;
            trk_d.in_run    = 1'b1;
            // Strict compare keeps the earlier of two equal windows.
            if (!any_q || (cur_width > best_width)) begin
               trk_d.best_start = cur_start;
               trk_d.best_end   = tap;
               any_d            = 1'b1;
            end
         end else begin
            trk_d.in_run = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_q <= '0;
         any_q <= 1'b0;
      end else begin
         trk_q <= trk_d;
         any_q <= any_d;
      end
   end

endmodule

// File: rtl/iodelay_tap_sweep_ctrl.sv
// Per-lane IODELAY tap sweep and centring sequencer (app_clk domain).
// For each sweep point: drop EN_VTC, load the tap, raise EN_VTC, sample the
// checker's sticky error; afterwards load the centre of the longest passing window.
//   clk, rst        : app_clk, async active-high reset
//   start_i         : calibration start pulse (ignored while busy_o)
//   error_sb_i      : sticky lane error, cleared by the checker on EN_VTC fall
//   en_vtc_o        : EN_VTC to delay element and checker
//   dly_load_o      : one-cycle delay load strobe
//   dly_cntvalue_o  : tap to load, stable between loads
//   busy_o, done_o, fail_o : status (fail_o valid with done_o)
//   win_start_o, win_end_o, final_tap_o : calibration result
module iodelay_tap_sweep_ctrl
   import lrx_cal_pkg::*;
#(
   parameter int unsigned TAP_W      = TAP_W_DEF,
   parameter int unsigned TAP_MAX    = 511,
   parameter int unsigned TAP_STEP   = 8,
   parameter int unsigned SETTLE_CYC = 16,
   parameter int unsigned CHECK_CYC  = 256,
   parameter int unsigned MIN_WINDOW = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             error_sb_i,
   output logic             en_vtc_o,
   output logic             dly_load_o,
   output logic [TAP_W-1:0] dly_cntvalue_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             fail_o,
   output logic [TAP_W-1:0] win_start_o,
   output logic [TAP_W-1:0] win_end_o,
   output logic [TAP_W-1:0] final_tap_o
);

   localparam int unsigned TmrMax = (CHECK_CYC > SETTLE_CYC) ? CHECK_CYC : SETTLE_CYC;
   localparam int unsigned TmrW   = $clog2(TmrMax);
   localparam logic [TmrW-1:0] SettleLd = TmrW'(SETTLE_CYC - 1);
   localparam logic [TmrW-1:0] CheckLd  = TmrW'(CHECK_CYC - 1);

   // The tracker record in the package is sized for the default tap width.
   if (TAP_W != TAP_W_DEF) begin : g_bad_tap_w
      $error("TAP_W must equal lrx_cal_pkg::TAP_W_DEF");
   end

   cal_state_e       state_q, state_d;
   logic [TAP_W-1:0] tap_q, tap_d;
   logic [TAP_W-1:0] cnt_q, cnt_d;
   logic [TAP_W-1:0] final_tap_q, final_tap_d;
   logic [TmrW-1:0]  timer_q, timer_d;
   logic             final_phase_q, final_phase_d;
   logic             sample_q, sample_d;
   logic             done_q, done_d;
   logic             fail_q, fail_d;

   logic             trk_clear, trk_eval;
   logic [TAP_W-1:0] best_start, best_end, best_width, centre;
   logic             any_pass, win_fail, tap_over;
   logic [TAP_W:0]   tap_next;

   // One extra bit so the last-point test cannot wrap.
   assign tap_next = {1'b0, tap_q} + (TAP_W+1)'(TAP_STEP);
   assign tap_over = tap_next > (TAP_W+1)'(TAP_MAX);
   assign centre   = best_start + (best_width >> 1);
   assign win_fail = !any_pass || (best_width < TAP_W'(MIN_WINDOW));
   assign trk_eval = (state_q == StEval) && !final_phase_q;

   cal_window_tracker u_tracker (
      .clk        (clk),
      .rst        (rst),
      .clear      (trk_clear),
      .eval       (trk_eval),
      .pass       (!sample_q),
      .tap        (tap_q),
      .best_start (best_start),
      .best_end   (best_end),
      .best_width (best_width),
      .any_pass   (any_pass)
   );

   always_comb begin
      state_d       = state_q;
      tap_d         = tap_q;
      cnt_d         = cnt_q;
      final_tap_d   = final_tap_q;
      timer_d       = (timer_q != '0) ? timer_q - 1'b1 : timer_q;
      final_phase_d = final_phase_q;
      sample_d      = sample_q;
      done_d        = done_q;
      fail_d        = fail_q;
      trk_clear     = 1'b0;
      case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d       = StVtcLow;
               tap_d         = '0;
               timer_d       = SettleLd;
               final_phase_d = 1'b0;
               done_d        = 1'b0;
               fail_d        = 1'b0;
               final_tap_d   = '0;
               trk_clear     = 1'b1;
            end else if (state_q == StDone) begin
               state_d = StIdle;
            end
         end
         StVtcLow: begin
            if (timer_q == '0) begin
               state_d = StLoad;
               cnt_d   = tap_q;
            end
         end
         StLoad: begin
            state_d = StLoadWait;
            timer_d = SettleLd;
         end
         StLoadWait: begin
            if (timer_q == '0) begin
               state_d = StVtcHigh;
               timer_d = CheckLd;
            end
         end
         StVtcHigh: begin
            if (timer_q == '0) begin
               state_d  = StEval;
               sample_d = error_sb_i;
            end
         end
         StEval: state_d = StStep;
         StStep: begin
            if (final_phase_q) begin
               state_d     = StDone;
               done_d      = 1'b1;
               final_tap_d = tap_q;
            end else if (tap_over) begin
               state_d = StFinal;
            end else begin
               state_d = StVtcLow;
               tap_d   = tap_next[TAP_W-1:0];
               timer_d = SettleLd;
            end
         end
         StFinal: begin
            if (win_fail) begin
               state_d     = StDone;
               done_d      = 1'b1;
               fail_d      = 1'b1;
               final_tap_d = '0;
            end else begin
               state_d       = StVtcLow;
               tap_d         = centre;
               final_phase_d = 1'b1;
               timer_d       = SettleLd;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= StIdle;
         tap_q         <= '0;
         cnt_q         <= '0;
         final_tap_q   <= '0;
         timer_q       <= '0;
         final_phase_q <= 1'b0;
         sample_q      <= 1'b0;
         done_q        <= 1'b0;
         fail_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         tap_q         <= tap_d;
         cnt_q         <= cnt_d;
         final_tap_q   <= final_tap_d;
         timer_q       <= timer_d;
         final_phase_q <= final_phase_d;
         sample_q      <= sample_d;
         done_q        <= done_d;
         fail_q        <= fail_d;
      end
   end

   // EN_VTC is decoded from state so it only moves on transitions and is low around loads.
   assign en_vtc_o       = !(state_q inside {StVtcLow, StLoad, StLoadWait});
   assign dly_load_o     = (state_q == StLoad);
   assign busy_o         = !(state_q inside {StIdle, StDone});
   assign dly_cntvalue_o = cnt_q;
   assign done_o         = done_q;
   assign fail_o         = fail_q;
   assign final_tap_o    = final_tap_q;
   assign win_start_o    = best_start;
   assign win_end_o      = best_end;

endmodule

// File: tb/tb_iodelay_tap_sweep_ctrl.sv
module tb_iodelay_tap_sweep_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start_i = 1'b0;
   logic       error_sb = 1'b0;
   logic       en_vtc_o, dly_load_o, busy_o, done_o, fail_o;
   logic [8:0] dly_cntvalue_o, win_start_o, win_end_o, final_tap_o;

   int checks = 0;
   int errors = 0;

   // Lane checker model state
   int lo1 = 0, hi1 = 511, lo2 = -1, hi2 = -1;
   bit ferr = 1'b0;
   int ld_tap = 0;
   int load_cnt = 0;
   bit vtc_prev = 1'b1;

   iodelay_tap_sweep_ctrl #(
      .SETTLE_CYC (2),
      .CHECK_CYC  (10)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
      .error_sb_i     (error_sb),
      .en_vtc_o       (en_vtc_o),
      .dly_load_o     (dly_load_o),
      .dly_cntvalue_o (dly_cntvalue_o),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .fail_o         (fail_o),
      .win_start_o    (win_start_o),
      .win_end_o      (win_end_o),
      .final_tap_o    (final_tap_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic bit tap_bad(input int t);
      bit ok;
      ok = ((t >= lo1) && (t <= hi1)) || ((t >= lo2) && (t <= hi2));
      return !ok || (ferr && (load_cnt >= 65));
   endfunction

   // Sticky error: cleared on EN_VTC fall, set while EN_VTC is high on a bad tap.
   always @(negedge clk) begin
      if (dly_load_o) begin
         check("load_with_vtc_low", {31'd0, en_vtc_o}, 32'd0);
         ld_tap = int'(dly_cntvalue_o);
         load_cnt++;
      end
      if (vtc_prev && !en_vtc_o) error_sb = 1'b0;
      else if (en_vtc_o && tap_bad(ld_tap)) error_sb = 1'b1;
      vtc_prev = en_vtc_o;
   end

   task automatic pulse_start();
      @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic run_cal(input string name, input int l1, input int h1, input int l2,
                          input int h2, input bit fe, input bit extra,
                          input int exp_fail, input int exp_ws, input int exp_we,
                          input int exp_ft, input int exp_loads, input int exp_cnt);
      bit seen;
      lo1 = l1; hi1 = h1; lo2 = l2; hi2 = h2; ferr = fe;
      load_cnt = 0;
      pulse_start();
      check({name, "_busy"}, {31'd0, busy_o}, 32'd1);
      check({name, "_done_clr"}, {31'd0, done_o}, 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (extra && (i == 100)) pulse_start();
         @(negedge clk);
         if (done_o) begin
            seen = 1'b1;
            break;
         end
      end
      check({name, "_done"}, {31'd0, seen}, 32'd1);
      check({name, "_fail"}, {31'd0, fail_o}, exp_fail);
      check({name, "_ws"}, {23'd0, win_start_o}, exp_ws);
      check({name, "_we"}, {23'd0, win_end_o}, exp_we);
      check({name, "_ft"}, {23'd0, final_tap_o}, exp_ft);
      check({name, "_loads"}, load_cnt, exp_loads);
      check({name, "_cnt"}, {23'd0, dly_cntvalue_o}, exp_cnt);
      check({name, "_vtc"}, {31'd0, en_vtc_o}, 32'd1);
      @(negedge clk);
      check({name, "_idle"}, {31'd0, busy_o}, 32'd0);
   endtask

   initial begin
      bit found;
      #3;
      check("rst_vtc", {31'd0, en_vtc_o}, 32'd1);
      check("rst_busy", {31'd0, busy_o}, 32'd0);
      check("rst_done", {31'd0, done_o}, 32'd0);
      check("rst_fail", {31'd0, fail_o}, 32'd0);
      check("rst_load", {31'd0, dly_load_o}, 32'd0);
      check("rst_cnt", {23'd0, dly_cntvalue_o}, 32'd0);
      check("rst_ft", {23'd0, final_tap_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_cal("allpass", 0, 511, -1, -1, 0, 0, 0, 0, 504, 252, 65, 252);
      run_cal("win96", 96, 200, -1, -1, 0, 0, 0, 96, 200, 148, 65, 148);
      run_cal("two_win", 16, 48, 304, 400, 0, 0, 0, 304, 400, 352, 65, 352);
      run_cal("tie_win", 16, 48, 304, 336, 0, 0, 0, 16, 48, 32, 65, 32);
      run_cal("allfail", 1000, -1, -1, -1, 0, 0, 1, 0, 0, 0, 64, 504);
      run_cal("single", 256, 256, -1, -1, 0, 0, 1, 256, 256, 0, 64, 504);
      run_cal("final_err", 0, 511, -1, -1, 1, 0, 0, 0, 504, 252, 65, 252);

      // Asynchronous reset during LOAD_WAIT of tap 40
      lo1 = 0; hi1 = 511; lo2 = -1; hi2 = -1; ferr = 1'b0;
      pulse_start();
      found = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (dly_load_o && (dly_cntvalue_o == 9'd40)) begin
            found = 1'b1;
            break;
         end
      end
      check("tap40_load", {31'd0, found}, 32'd1);
      @(negedge clk);
      check("pre_rst_busy", {31'd0, busy_o}, 32'd1);
      check("pre_rst_vtc", {31'd0, en_vtc_o}, 32'd0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_vtc", {31'd0, en_vtc_o}, 32'd1);
      check("async_rst_busy", {31'd0, busy_o}, 32'd0);
      check("async_rst_load", {31'd0, dly_load_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_cal("restart", 0, 511, -1, -1, 0, 1, 0, 0, 504, 252, 65, 252);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
